// File: rtl/iccm_port_arbiter_if.sv
// Bus bundle for the ICCM port arbiter: fetch port, boot-programmer port and
// the shared instr_mem_top request/response channel.
interface iccm_port_arbiter_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
);
  logic          f_req_i;
  logic [AW-1:0] f_addr_i;
  logic          f_gnt_o;
  logic [DW-1:0] f_rdata_o;
  logic          f_rvalid_o;

  logic          p_req_i;
  logic          p_we_i;
  logic [AW-1:0] p_addr_i;
  logic [DW-1:0] p_wdata_i;
  logic          p_gnt_o;
  logic [DW-1:0] p_rdata_o;
  logic          p_rvalid_o;

  logic          boot_done_i;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_rvalid_i;

  logic          boot_mode_o;
  logic          err_o;

  // Arbiter side
  modport slave (
    input  f_req_i, f_addr_i,
    output f_gnt_o, f_rdata_o, f_rvalid_o,
    input  p_req_i, p_we_i, p_addr_i, p_wdata_i,
    output p_gnt_o, p_rdata_o, p_rvalid_o,
    input  boot_done_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_rvalid_i,
    output boot_mode_o, err_o
  );

  // Requesters and memory side
  modport master (
    output f_req_i, f_addr_i,
    input  f_gnt_o, f_rdata_o, f_rvalid_o,
    output p_req_i, p_we_i, p_addr_i, p_wdata_i,
    input  p_gnt_o, p_rdata_o, p_rvalid_o,
    output boot_done_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_rvalid_i,
    input  boot_mode_o, err_o
  );
endinterface

// File: rtl/iccm_port_arbiter.sv
// ICCM port arbiter: programmer owns the memory in BOOT, fetch and programmer share it in RUN.
// Define ICCM_ARB_RR_EN for round-robin RUN arbitration; default is fetch-over-programmer priority.
module iccm_port_arbiter #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  iccm_port_arbiter_if.slave bus
);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;
  typedef enum logic {PORT_P = 1'b0, PORT_F = 1'b1} port_t;

  state_t        state_q, state_d;
  port_t         owner_q;
  logic          pending_q;
  logic          err_q;
  logic          f_gnt, p_gnt;
  logic          mem_we;
  logic          rd_gnt;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

`ifdef ICCM_ARB_RR_EN
  port_t         rr_q, rr_d;
`endif

  // Next state and grant decode; nothing is granted while reset is held
  always_comb begin
    state_d = state_q;
    f_gnt   = 1'b0;
    p_gnt   = 1'b0;
`ifdef ICCM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    if (!rst_i) begin
      case (state_q)
        ST_BOOT: begin
          p_gnt = bus.p_req_i;
          if (bus.boot_done_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.f_req_i && bus.p_req_i) begin
`ifdef ICCM_ARB_RR_EN
            if (rr_q == PORT_F) begin
              f_gnt = 1'b1;
              rr_d  = PORT_P;
            end else begin
              p_gnt = 1'b1;
              rr_d  = PORT_F;
            end
`else
            f_gnt = 1'b1;
`endif
          end else begin
            f_gnt = bus.f_req_i;
            p_gnt = bus.p_req_i;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // Only the programmer can write; fetch grants always present a read
  assign mem_we    = p_gnt & bus.p_we_i;
  assign rd_gnt    = (f_gnt | p_gnt) & ~mem_we;
  assign addr_mux  = f_gnt ? bus.f_addr_i : bus.p_addr_i;
  assign wdata_mux = bus.p_wdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_BOOT;
      pending_q <= 1'b0;
      owner_q   <= PORT_P;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= rd_gnt;
      if (rd_gnt) owner_q <= f_gnt ? PORT_F : PORT_P;
      if (bus.mem_rvalid_i && !pending_q) err_q <= 1'b1;
    end
  end

`ifdef ICCM_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= PORT_F;
    else       rr_q <= rr_d;
  end
`endif

  assign bus.f_gnt_o     = f_gnt;
  assign bus.p_gnt_o     = p_gnt;
  assign bus.mem_req_o   = f_gnt | p_gnt;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = addr_mux;
  assign bus.mem_wdata_o = wdata_mux;

  // Response routing; unexpected responses are dropped here and flagged via err_q
  assign bus.f_rvalid_o  = bus.mem_rvalid_i & pending_q & (owner_q == PORT_F);
  assign bus.p_rvalid_o  = bus.mem_rvalid_i & pending_q & (owner_q == PORT_P);
  assign bus.f_rdata_o   = bus.mem_rdata_i;
  assign bus.p_rdata_o   = bus.mem_rdata_i;

  assign bus.boot_mode_o = (state_q == ST_BOOT);
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed self-checking bench for iccm_port_arbiter with a 1-cycle-latency memory model.
module tb_iccm_port_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  iccm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  iccm_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Memory model: writes land at the edge, reads return one cycle after the grant
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          rv_q = 1'b0;
  logic [DW-1:0] rd_q = '0;
  logic          inject = 1'b0;

  always @(posedge clk_i) begin
    if (bus.mem_req_o && bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
    rv_q <= bus.mem_req_o & ~bus.mem_we_o;
    rd_q <= mem[bus.mem_addr_o];
  end

  assign bus.mem_rvalid_i = rv_q | inject;
  assign bus.mem_rdata_i  = rd_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic drive(input logic fr, input logic [AW-1:0] fa,
                       input logic pr, input logic pw, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd, input logic bd);
    @(negedge clk_i);
    bus.f_req_i     = fr;
    bus.f_addr_i    = fa;
    bus.p_req_i     = pr;
    bus.p_we_i      = pw;
    bus.p_addr_i    = pa;
    bus.p_wdata_i   = pd;
    bus.boot_done_i = bd;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b1, 12'h010, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0);
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req_o); end
    n_cmp++; if (bus.p_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst_p_gnt got=%0h exp=0", bus.p_gnt_o); end
    n_cmp++; if (bus.f_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst_f_gnt got=%0h exp=0", bus.f_gnt_o); end
    n_cmp++; if (bus.boot_mode_o !== 1'b1) begin n_bad++; $display("FAIL rst_boot_mode got=%0h exp=1", bus.boot_mode_o); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%0h exp=0", bus.err_o); end
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    rst_i = 1'b0;
  endtask

  task automatic test_boot_write();
    drive(1'b1, 12'h010, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0);
    n_cmp++; if (bus.p_gnt_o !== 1'b1) begin n_bad++; $display("FAIL boot_p_gnt got=%0h exp=1", bus.p_gnt_o); end
    n_cmp++; if (bus.f_gnt_o !== 1'b0) begin n_bad++; $display("FAIL boot_f_gnt got=%0h exp=0", bus.f_gnt_o); end
    n_cmp++; if (bus.mem_we_o !== 1'b1) begin n_bad++; $display("FAIL boot_mem_we got=%0h exp=1", bus.mem_we_o); end
    n_cmp++; if (bus.mem_addr_o !== 12'h010) begin n_bad++; $display("FAIL boot_mem_addr got=%0h exp=010", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_wdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL boot_mem_wdata got=%0h exp=deadbeef", bus.mem_wdata_o); end
    n_cmp++; if (bus.boot_mode_o !== 1'b1) begin n_bad++; $display("FAIL boot_mode got=%0h exp=1", bus.boot_mode_o); end
    drive(1'b1, 12'h010, 1'b1, 1'b1, 12'h020, 32'h12345678, 1'b0);
    n_cmp++; if (bus.p_rvalid_o !== 1'b0 || bus.f_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL boot_write_no_rvalid got=%0h%0h exp=00", bus.p_rvalid_o, bus.f_rvalid_o); end
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    n_cmp++; if (bus.p_rvalid_o !== 1'b0 || bus.err_o !== 1'b0) begin n_bad++; $display("FAIL boot_write2_no_rvalid got=%0h err=%0h exp=0", bus.p_rvalid_o, bus.err_o); end
  endtask

  task automatic test_boot_done();
    // Programmer read in the boot_done cycle is still served under BOOT rules
    drive(1'b1, 12'h010, 1'b1, 1'b0, 12'h010, 32'h0, 1'b1);
    n_cmp++; if (bus.p_gnt_o !== 1'b1) begin n_bad++; $display("FAIL bd_p_gnt got=%0h exp=1", bus.p_gnt_o); end
    n_cmp++; if (bus.f_gnt_o !== 1'b0) begin n_bad++; $display("FAIL bd_f_gnt got=%0h exp=0", bus.f_gnt_o); end
    drive(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    n_cmp++; if (bus.boot_mode_o !== 1'b0) begin n_bad++; $display("FAIL run_boot_mode got=%0h exp=0", bus.boot_mode_o); end
    n_cmp++; if (bus.p_rvalid_o !== 1'b1 || bus.p_rdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bd_p_rvalid got=%0h/%0h exp=1/deadbeef", bus.p_rvalid_o, bus.p_rdata_o); end
    n_cmp++; if (bus.f_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin n_bad++; $display("FAIL run_f_gnt got=%0h we=%0h exp=1/0", bus.f_gnt_o, bus.mem_we_o); end
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    n_cmp++; if (bus.f_rvalid_o !== 1'b1 || bus.f_rdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL run_f_rvalid got=%0h/%0h exp=1/deadbeef", bus.f_rvalid_o, bus.f_rdata_o); end
    n_cmp++; if (bus.p_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL run_p_rvalid got=%0h exp=0", bus.p_rvalid_o); end
  endtask

  task automatic test_contention();
    logic exp_f [4];
`ifdef ICCM_ARB_RR_EN
    exp_f = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_f = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0);
      n_cmp++; if (bus.f_gnt_o !== exp_f[i] || bus.p_gnt_o !== ~exp_f[i]) begin n_bad++; $display("FAIL cont_gnt[%0d] got f=%0h p=%0h exp f=%0h", i, bus.f_gnt_o, bus.p_gnt_o, exp_f[i]); end
      if (i > 0) begin
        n_cmp++; if (bus.f_rvalid_o !== exp_f[i-1] || bus.p_rvalid_o !== ~exp_f[i-1] || bus.f_rdata_o !== (exp_f[i-1] ? 32'hDEADBEEF : 32'h12345678)) begin n_bad++; $display("FAIL cont_rvalid[%0d] got f=%0h p=%0h d=%0h", i, bus.f_rvalid_o, bus.p_rvalid_o, bus.f_rdata_o); end
      end
    end
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    n_cmp++; if (bus.f_rvalid_o !== exp_f[3] || bus.p_rvalid_o !== ~exp_f[3]) begin n_bad++; $display("FAIL cont_last_rvalid got f=%0h p=%0h exp f=%0h", bus.f_rvalid_o, bus.p_rvalid_o, exp_f[3]); end
  endtask

  task automatic test_back_to_back();
    // Lone fetch with programmer write data pending: fetch must still read
    drive(1'b1, 12'h020, 1'b0, 1'b1, 12'h030, 32'hCAFEF00D, 1'b0);
    n_cmp++; if (bus.f_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 12'h020) begin n_bad++; $display("FAIL b2b_f_rd got g=%0h we=%0h a=%0h exp 1/0/020", bus.f_gnt_o, bus.mem_we_o, bus.mem_addr_o); end
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h030, 32'hCAFEF00D, 1'b0);
    n_cmp++; if (bus.p_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b1) begin n_bad++; $display("FAIL b2b_p_wr got g=%0h we=%0h exp 1/1", bus.p_gnt_o, bus.mem_we_o); end
    n_cmp++; if (bus.f_rvalid_o !== 1'b1 || bus.f_rdata_o !== 32'h12345678) begin n_bad++; $display("FAIL b2b_f_rvalid got %0h/%0h exp 1/12345678", bus.f_rvalid_o, bus.f_rdata_o); end
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h030, 32'h0, 1'b0);
    n_cmp++; if (bus.p_gnt_o !== 1'b1 || bus.p_rvalid_o !== 1'b0 || bus.f_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_p_rd got g=%0h prv=%0h frv=%0h exp 1/0/0", bus.p_gnt_o, bus.p_rvalid_o, bus.f_rvalid_o); end
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    n_cmp++; if (bus.p_rvalid_o !== 1'b1 || bus.p_rdata_o !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_p_rvalid got %0h/%0h exp 1/cafef00d", bus.p_rvalid_o, bus.p_rdata_o); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL b2b_err got=%0h exp=0", bus.err_o); end
  endtask

  task automatic test_spurious();
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    inject = 1'b1;
    #1;
    n_cmp++; if (bus.f_rvalid_o !== 1'b0 || bus.p_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL spur_rvalid got f=%0h p=%0h exp 0/0", bus.f_rvalid_o, bus.p_rvalid_o); end
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    inject = 1'b0;
    n_cmp++; if (bus.err_o !== 1'b1) begin n_bad++; $display("FAIL spur_err got=%0h exp=1", bus.err_o); end
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    n_cmp++; if (bus.err_o !== 1'b1) begin n_bad++; $display("FAIL spur_err_sticky got=%0h exp=1", bus.err_o); end
  endtask

  task automatic test_reset_midread();
    drive(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    n_cmp++; if (bus.f_gnt_o !== 1'b1) begin n_bad++; $display("FAIL mid_f_gnt got=%0h exp=1", bus.f_gnt_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.f_req_i = 1'b0;
    #1;
    n_cmp++; if (bus.f_rvalid_o !== 1'b0 || bus.p_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid got f=%0h p=%0h exp 0/0", bus.f_rvalid_o, bus.p_rvalid_o); end
    n_cmp++; if (bus.err_o !== 1'b0 || bus.boot_mode_o !== 1'b1) begin n_bad++; $display("FAIL mid_state got err=%0h boot=%0h exp 0/1", bus.err_o, bus.boot_mode_o); end
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    rst_i = 1'b0;
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    n_cmp++; if (bus.err_o !== 1'b0 || bus.boot_mode_o !== 1'b1 || bus.f_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL mid_after got err=%0h boot=%0h frv=%0h exp 0/1/0", bus.err_o, bus.boot_mode_o, bus.f_rvalid_o); end
  endtask

  initial begin
    bus.f_req_i     = 1'b0;
    bus.f_addr_i    = '0;
    bus.p_req_i     = 1'b0;
    bus.p_we_i      = 1'b0;
    bus.p_addr_i    = '0;
    bus.p_wdata_i   = '0;
    bus.boot_done_i = 1'b0;
    test_reset();
    test_boot_write();
    test_boot_done();
    test_contention();
    test_back_to_back();
    test_spurious();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
